lc3_control: RTL and testbench

Sequencing FSM for the 16-bit LC-3 datapath. It issues every datapath control strobe, one-hot bus gate and mux select for fetch, decode and execute. It also runs a handshake with synchronous SRAM that needs a fixed number of wait cycles. It sits beside the datapath in the lab top level and consumes only IR, BEN and the external Run/Continue buttons.

---
 rtl/lc3_control_pkg.sv | 56 +++++
 rtl/lc3_control_if.sv | 30 +++
 rtl/lc3_control_mem_wait_ctr.sv | 21 ++
 rtl/lc3_control.sv | 119 +++++++++++
 tb/tb_lc3_control.sv | 242 ++++++++++++++++++++++++
 5 files changed

// File: rtl/lc3_control_pkg.sv
// Shared types and encodings for the LC-3 sequencing FSM: state set,
// opcode values and datapath mux-select codes.
package lc3_pkg;

    typedef enum logic [4:0] {
        S_HALTED,
        S_F1, S_F2, S_F3, S_DEC,
        S_ADD, S_AND, S_NOT,
        S_BR, S_BR_T,
        S_JMP, S_JSR1, S_JSR2,
        S_LDR1, S_LDR2, S_LDR3,
        S_STR1, S_STR2, S_STR3,
        S_PAUSE1, S_PAUSE2
    } state_t;

    localparam logic [3:0] OP_BR    = 4'b0000;
    localparam logic [3:0] OP_ADD   = 4'b0001;
    localparam logic [3:0] OP_JSR   = 4'b0100;
    localparam logic [3:0] OP_AND   = 4'b0101;
    localparam logic [3:0] OP_LDR   = 4'b0110;
    localparam logic [3:0] OP_STR   = 4'b0111;
    localparam logic [3:0] OP_NOT   = 4'b1001;
    localparam logic [3:0] OP_JMP   = 4'b1100;
    localparam logic [3:0] OP_PAUSE = 4'b1101;

    localparam logic [1:0] PCMUX_INC  = 2'b00;
    localparam logic [1:0] PCMUX_BUS  = 2'b01;
    localparam logic [1:0] PCMUX_ADDR = 2'b10;

    localparam logic [1:0] ADDR2_ZERO  = 2'b00;
    localparam logic [1:0] ADDR2_OFF6  = 2'b01;
    localparam logic [1:0] ADDR2_OFF9  = 2'b10;
    localparam logic [1:0] ADDR2_OFF11 = 2'b11;

    localparam logic [1:0] ALUK_ADD   = 2'b00;
    localparam logic [1:0] ALUK_AND   = 2'b01;
    localparam logic [1:0] ALUK_NOT   = 2'b10;
    localparam logic [1:0] ALUK_PASSA = 2'b11;

    // Unsupported opcodes fall back to a fresh fetch (executed as a NOP).
    function automatic state_t decode_op(input logic [3:0] op);
        case (op)
            OP_ADD:   return S_ADD;
            OP_AND:   return S_AND;
            OP_NOT:   return S_NOT;
            OP_BR:    return S_BR;
            OP_JMP:   return S_JMP;
            OP_JSR:   return S_JSR1;
            OP_LDR:   return S_LDR1;
            OP_STR:   return S_STR1;
            OP_PAUSE: return S_PAUSE1;
            default:  return S_F1;
        endcase
    endfunction

endpackage

// File: rtl/lc3_control_if.sv
// Control bundle between the LC-3 sequencer (master) and the datapath (slave).
interface lc3_control_if;
    logic        Run;
    logic        Continue;
    logic [15:0] IR;
    logic        BEN;

    logic LD_MAR, LD_MDR, LD_IR, LD_BEN, LD_CC, LD_REG, LD_PC, LD_LED;
    logic GatePC, GateMDR, GateALU, GateMARMUX;
    logic SR2MUX, ADDR1MUX, MARMUX, MIO_EN, DRMUX, SR1MUX;
    logic [1:0] PCMUX, ADDR2MUX, ALUK;
    logic Mem_OE, Mem_WE;
    logic Halted;

    modport master (
        input  Run, Continue, IR, BEN,
        output LD_MAR, LD_MDR, LD_IR, LD_BEN, LD_CC, LD_REG, LD_PC, LD_LED,
        output GatePC, GateMDR, GateALU, GateMARMUX,
        output SR2MUX, ADDR1MUX, MARMUX, MIO_EN, DRMUX, SR1MUX,
        output PCMUX, ADDR2MUX, ALUK, Mem_OE, Mem_WE, Halted
    );

    modport slave (
        output Run, Continue, IR, BEN,
        input  LD_MAR, LD_MDR, LD_IR, LD_BEN, LD_CC, LD_REG, LD_PC, LD_LED,
        input  GatePC, GateMDR, GateALU, GateMARMUX,
        input  SR2MUX, ADDR1MUX, MARMUX, MIO_EN, DRMUX, SR1MUX,
        input  PCMUX, ADDR2MUX, ALUK, Mem_OE, Mem_WE, Halted
    );
endinterface

// File: rtl/lc3_control_mem_wait_ctr.sv
// SRAM wait counter: counts cycles a memory strobe has been held; done marks
// the last wait cycle, when read data is valid or the write commits.
module mem_wait_ctr #(
    parameter int MEM_WAIT = 2
) (
    input  logic Clk,
    input  logic Reset,
    input  logic clr,
    input  logic en,
    output logic done
);
    logic [2:0] cnt;

    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset)    cnt <= '0;
        else if (clr)  cnt <= '0;
        else if (en)   cnt <= cnt + 3'd1;
    end

    assign done = (cnt == 3'(MEM_WAIT - 1));
endmodule

// File: rtl/lc3_control.sv
// LC-3 sequencing FSM: fetch/decode/execute control strobes plus the SRAM
// wait handshake. Outputs are Moore decodes of the state register and IR.
module lc3_control
    import lc3_pkg::*;
#(
    parameter int MEM_WAIT = 2
) (
    input  logic          Clk,
    input  logic          Reset,
    lc3_control_if.master bus
);
    state_t state;
    logic   pause_seen;
    logic   mem_en, mem_done;
    logic   unused_ir;

    assign unused_ir = ^{bus.IR[11:6], bus.IR[4:0]};
    assign mem_en    = (state == S_F2) || (state == S_LDR2) || (state == S_STR3);

    mem_wait_ctr #(.MEM_WAIT(MEM_WAIT)) u_wait (
        .Clk   (Clk),
        .Reset (Reset),
        .clr   (mem_en && mem_done),
        .en    (mem_en),
        .done  (mem_done)
    );

    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            state      <= S_HALTED;
            pause_seen <= 1'b0;
        end else begin
            // Remembers that PAUSE1 has already had its LED-load cycle.
            pause_seen <= (state == S_PAUSE1);
            case (state)
                S_HALTED: if (bus.Run) state <= S_F1;
                S_F1:     state <= S_F2;
                S_F2:     if (mem_done) state <= S_F3;
                S_F3:     state <= S_DEC;
                S_DEC:    state <= decode_op(bus.IR[15:12]);
                S_BR:     state <= bus.BEN ? S_BR_T : S_F1;
                S_JSR1:   state <= S_JSR2;
                S_LDR1:   state <= S_LDR2;
                S_LDR2:   if (mem_done) state <= S_LDR3;
                S_STR1:   state <= S_STR2;
                S_STR2:   state <= S_STR3;
                S_STR3:   if (mem_done) state <= S_F1;
                S_PAUSE1: if (bus.Continue) state <= S_PAUSE2;
                S_PAUSE2: if (!bus.Continue) state <= S_F1;
                S_ADD, S_AND, S_NOT, S_BR_T, S_JMP, S_JSR2, S_LDR3:
                          state <= S_F1;
                default:  state <= S_HALTED;
            endcase
        end
    end

    always_comb begin
        bus.LD_MAR = 1'b0;  bus.LD_MDR = 1'b0;  bus.LD_IR  = 1'b0;  bus.LD_BEN = 1'b0;
        bus.LD_CC  = 1'b0;  bus.LD_REG = 1'b0;  bus.LD_PC  = 1'b0;  bus.LD_LED = 1'b0;
        bus.GatePC = 1'b0;  bus.GateMDR = 1'b0; bus.GateALU = 1'b0; bus.GateMARMUX = 1'b0;
        bus.SR2MUX = 1'b0;  bus.ADDR1MUX = 1'b0; bus.MARMUX = 1'b0; bus.MIO_EN = 1'b0;
        bus.DRMUX  = 1'b0;  bus.SR1MUX = 1'b0;
        bus.PCMUX  = PCMUX_INC;
        bus.ADDR2MUX = ADDR2_ZERO;
        bus.ALUK   = ALUK_ADD;
        bus.Mem_OE = 1'b0;  bus.Mem_WE = 1'b0;  bus.Halted = 1'b0;
        case (state)
            S_HALTED: bus.Halted = 1'b1;
            S_F1: begin
                bus.GatePC = 1'b1; bus.LD_MAR = 1'b1; bus.LD_PC = 1'b1;
                bus.PCMUX  = PCMUX_INC;
            end
            S_F2, S_LDR2: begin
                bus.Mem_OE = 1'b1; bus.MIO_EN = 1'b1; bus.LD_MDR = mem_done;
            end
            S_F3: begin
                bus.GateMDR = 1'b1; bus.LD_IR = 1'b1;
            end
            S_DEC: bus.LD_BEN = 1'b1;
            S_ADD, S_AND, S_NOT: begin
                bus.GateALU = 1'b1; bus.LD_REG = 1'b1; bus.LD_CC = 1'b1; bus.SR1MUX = 1'b1;
                bus.SR2MUX  = (state != S_NOT) && bus.IR[5];
                bus.ALUK    = (state == S_ADD) ? ALUK_ADD :
                              (state == S_AND) ? ALUK_AND : ALUK_NOT;
            end
            S_BR_T: begin
                bus.ADDR2MUX = ADDR2_OFF9; bus.PCMUX = PCMUX_ADDR; bus.LD_PC = 1'b1;
            end
            S_JMP: begin
                bus.SR1MUX = 1'b1; bus.ALUK = ALUK_PASSA; bus.GateALU = 1'b1;
                bus.PCMUX  = PCMUX_BUS; bus.LD_PC = 1'b1;
            end
            S_JSR1: begin
                bus.GatePC = 1'b1; bus.DRMUX = 1'b1; bus.LD_REG = 1'b1;
            end
            S_JSR2: begin
                bus.ADDR2MUX = ADDR2_OFF11; bus.PCMUX = PCMUX_ADDR; bus.LD_PC = 1'b1;
            end
            S_LDR1, S_STR1: begin
                bus.ADDR1MUX = 1'b1; bus.SR1MUX = 1'b1; bus.ADDR2MUX = ADDR2_OFF6;
                bus.GateMARMUX = 1'b1; bus.LD_MAR = 1'b1;
            end
            S_LDR3: begin
                bus.GateMDR = 1'b1; bus.LD_REG = 1'b1; bus.LD_CC = 1'b1;
            end
            S_STR2: begin
                bus.ALUK = ALUK_PASSA; bus.GateALU = 1'b1; bus.LD_MDR = 1'b1;
            end
            S_STR3:   bus.Mem_WE = 1'b1;
            S_PAUSE1: bus.LD_LED = !pause_seen;
            default: ;
        endcase
    end

    a_one_gate: assert property (@(posedge Clk) disable iff (!Reset)
        $countones({bus.GatePC, bus.GateMDR, bus.GateALU, bus.GateMARMUX}) <= 1);
    a_mem_excl: assert property (@(posedge Clk) disable iff (!Reset)
        !(bus.Mem_OE && bus.Mem_WE));
endmodule

// File: tb/tb_lc3_control.sv
// Directed bench for the LC-3 sequencer: per-scenario tasks compare the full
// output vector against hand-derived expectations each cycle.
module tb_lc3_control;
    logic clk;
    logic rst_n;
    int   checks;
    int   errors;

    lc3_control_if bus ();

    lc3_control #(.MEM_WAIT(2)) dut (
        .Clk   (clk),
        .Reset (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Bit layout: LD_MAR(26) .. LD_LED(19), gates 18..15, scalar selects 14..9,
    // PCMUX 8:7, ADDR2MUX 6:5, ALUK 4:3, Mem_OE 2, Mem_WE 1, Halted 0.
    logic [26:0] obs;
    assign obs = {bus.LD_MAR, bus.LD_MDR, bus.LD_IR, bus.LD_BEN, bus.LD_CC, bus.LD_REG,
                  bus.LD_PC, bus.LD_LED, bus.GatePC, bus.GateMDR, bus.GateALU, bus.GateMARMUX,
                  bus.SR2MUX, bus.ADDR1MUX, bus.MARMUX, bus.MIO_EN, bus.DRMUX, bus.SR1MUX,
                  bus.PCMUX, bus.ADDR2MUX, bus.ALUK, bus.Mem_OE, bus.Mem_WE, bus.Halted};

    localparam logic [26:0] M_LD_MAR = 27'd1 << 26, M_LD_MDR = 27'd1 << 25, M_LD_IR = 27'd1 << 24;
    localparam logic [26:0] M_LD_BEN = 27'd1 << 23, M_LD_CC  = 27'd1 << 22, M_LD_REG = 27'd1 << 21;
    localparam logic [26:0] M_LD_PC  = 27'd1 << 20, M_LD_LED = 27'd1 << 19, M_GPC    = 27'd1 << 18;
    localparam logic [26:0] M_GMDR   = 27'd1 << 17, M_GALU   = 27'd1 << 16, M_GMARMUX = 27'd1 << 15;
    localparam logic [26:0] M_SR2    = 27'd1 << 14, M_ADDR1  = 27'd1 << 13, M_MIO    = 27'd1 << 11;
    localparam logic [26:0] M_DRMUX  = 27'd1 << 10, M_SR1    = 27'd1 << 9;
    localparam logic [26:0] M_OE     = 27'd1 << 2,  M_WE     = 27'd1 << 1,  M_HALT   = 27'd1;

    localparam logic [26:0] E_HALT  = M_HALT;
    localparam logic [26:0] E_F1    = M_GPC | M_LD_MAR | M_LD_PC;
    localparam logic [26:0] E_F2    = M_OE | M_MIO;
    localparam logic [26:0] E_F2L   = M_OE | M_MIO | M_LD_MDR;
    localparam logic [26:0] E_F3    = M_GMDR | M_LD_IR;
    localparam logic [26:0] E_DEC   = M_LD_BEN;
    localparam logic [26:0] E_ADD   = M_GALU | M_LD_REG | M_LD_CC | M_SR1;
    localparam logic [26:0] E_AND   = M_GALU | M_LD_REG | M_LD_CC | M_SR1 | M_SR2 | (27'd1 << 3);
    localparam logic [26:0] E_NOT   = M_GALU | M_LD_REG | M_LD_CC | M_SR1 | (27'd2 << 3);
    localparam logic [26:0] E_BRT   = M_LD_PC | (27'd2 << 5) | (27'd2 << 7);
    localparam logic [26:0] E_JMP   = M_SR1 | M_GALU | M_LD_PC | (27'd3 << 3) | (27'd1 << 7);
    localparam logic [26:0] E_JSR1  = M_GPC | M_DRMUX | M_LD_REG;
    localparam logic [26:0] E_JSR2  = M_LD_PC | (27'd3 << 5) | (27'd2 << 7);
    localparam logic [26:0] E_MADDR = M_ADDR1 | M_SR1 | M_GMARMUX | M_LD_MAR | (27'd1 << 5);
    localparam logic [26:0] E_LDR3  = M_GMDR | M_LD_REG | M_LD_CC;
    localparam logic [26:0] E_STR2  = M_GALU | M_LD_MDR | (27'd3 << 3);
    localparam logic [26:0] E_WE    = M_WE;
    localparam logic [26:0] E_IDLE  = 27'd0;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // F1 -> F2 -> F2 -> F3 -> DEC, unchecked; callers start observing F1.
    task automatic run_fetch();
        repeat (4) step();
    endtask

    task automatic test_reset();
        #2;
        checks++; if (obs !== E_HALT) begin errors++; $display("FAIL reset_halt got=%h exp=%h", obs, E_HALT); end
        @(negedge clk); rst_n = 1'b1;
        step(); step();
        checks++; if (obs !== E_HALT) begin errors++; $display("FAIL halt_no_run got=%h exp=%h", obs, E_HALT); end
        bus.Run = 1'b1;
        step();
        checks++; if (obs !== E_F1) begin errors++; $display("FAIL run_f1 got=%h exp=%h", obs, E_F1); end
        bus.Run = 1'b0;
        step();
        checks++; if (obs !== E_F2) begin errors++; $display("FAIL run_f2 got=%h exp=%h", obs, E_F2); end
        #2 rst_n = 1'b0;
        #1;
        checks++; if (obs !== E_HALT) begin errors++; $display("FAIL reset_mid_f2 got=%h exp=%h", obs, E_HALT); end
        @(negedge clk); rst_n = 1'b1; bus.Run = 1'b1;
        step();
        checks++; if (obs !== E_F1) begin errors++; $display("FAIL rerun_f1 got=%h exp=%h", obs, E_F1); end
        bus.Run = 1'b0;
    endtask

    task automatic test_fetch_add();
        bus.IR = 16'h1042;
        step();
        checks++; if (obs !== E_F2) begin errors++; $display("FAIL add_f2a got=%h exp=%h", obs, E_F2); end
        step();
        checks++; if (obs !== E_F2L) begin errors++; $display("FAIL add_f2b got=%h exp=%h", obs, E_F2L); end
        step();
        checks++; if (obs !== E_F3) begin errors++; $display("FAIL add_f3 got=%h exp=%h", obs, E_F3); end
        step();
        checks++; if (obs !== E_DEC) begin errors++; $display("FAIL add_dec got=%h exp=%h", obs, E_DEC); end
        step();
        checks++; if (obs !== E_ADD) begin errors++; $display("FAIL add_exec got=%h exp=%h", obs, E_ADD); end
        step();
        checks++; if (obs !== E_F1) begin errors++; $display("FAIL add_back_f1 got=%h exp=%h", obs, E_F1); end
    endtask

    task automatic test_alu_ops();
        bus.IR = 16'h5262;
        run_fetch(); step();
        checks++; if (obs !== E_AND) begin errors++; $display("FAIL and_exec got=%h exp=%h", obs, E_AND); end
        step();
        bus.IR = 16'h907F;
        run_fetch(); step();
        checks++; if (obs !== E_NOT) begin errors++; $display("FAIL not_exec got=%h exp=%h", obs, E_NOT); end
        step();
        checks++; if (obs !== E_F1) begin errors++; $display("FAIL not_back_f1 got=%h exp=%h", obs, E_F1); end
    endtask

    task automatic test_branch();
        bus.IR = 16'h0E05; bus.BEN = 1'b1;
        run_fetch(); step();
        checks++; if (obs !== E_IDLE) begin errors++; $display("FAIL br_state got=%h exp=%h", obs, E_IDLE); end
        step();
        checks++; if (obs !== E_BRT) begin errors++; $display("FAIL br_taken got=%h exp=%h", obs, E_BRT); end
        step();
        checks++; if (obs !== E_F1) begin errors++; $display("FAIL br_taken_f1 got=%h exp=%h", obs, E_F1); end
        bus.BEN = 1'b0;
        run_fetch(); step();
        checks++; if (obs !== E_IDLE) begin errors++; $display("FAIL br_nt_state got=%h exp=%h", obs, E_IDLE); end
        step();
        checks++; if (obs !== E_F1) begin errors++; $display("FAIL br_nt_f1 got=%h exp=%h", obs, E_F1); end
    endtask

    task automatic test_jmp_jsr();
        bus.IR = 16'hC1C0;
        run_fetch(); step();
        checks++; if (obs !== E_JMP) begin errors++; $display("FAIL jmp_exec got=%h exp=%h", obs, E_JMP); end
        step();
        bus.IR = 16'h4801;
        run_fetch(); step();
        checks++; if (obs !== E_JSR1) begin errors++; $display("FAIL jsr1 got=%h exp=%h", obs, E_JSR1); end
        step();
        checks++; if (obs !== E_JSR2) begin errors++; $display("FAIL jsr2 got=%h exp=%h", obs, E_JSR2); end
        step();
        checks++; if (obs !== E_F1) begin errors++; $display("FAIL jsr_f1 got=%h exp=%h", obs, E_F1); end
    endtask

    task automatic test_ldr();
        bus.IR = 16'h6042;
        run_fetch(); step();
        checks++; if (obs !== E_MADDR) begin errors++; $display("FAIL ldr1 got=%h exp=%h", obs, E_MADDR); end
        step();
        checks++; if (obs !== E_F2) begin errors++; $display("FAIL ldr2a got=%h exp=%h", obs, E_F2); end
        step();
        checks++; if (obs !== E_F2L) begin errors++; $display("FAIL ldr2b got=%h exp=%h", obs, E_F2L); end
        step();
        checks++; if (obs !== E_LDR3) begin errors++; $display("FAIL ldr3 got=%h exp=%h", obs, E_LDR3); end
        step();
        checks++; if (obs !== E_F1) begin errors++; $display("FAIL ldr_f1 got=%h exp=%h", obs, E_F1); end
    endtask

    task automatic test_str();
        bus.IR = 16'h7042;
        run_fetch(); step();
        checks++; if (obs !== E_MADDR) begin errors++; $display("FAIL str1 got=%h exp=%h", obs, E_MADDR); end
        step();
        checks++; if (obs !== E_STR2) begin errors++; $display("FAIL str2 got=%h exp=%h", obs, E_STR2); end
        step();
        checks++; if (obs !== E_WE) begin errors++; $display("FAIL str3a got=%h exp=%h", obs, E_WE); end
        step();
        checks++; if (obs !== E_WE) begin errors++; $display("FAIL str3b got=%h exp=%h", obs, E_WE); end
        step();
        checks++; if (obs !== E_F1) begin errors++; $display("FAIL str_f1 got=%h exp=%h", obs, E_F1); end
    endtask

    task automatic test_pause();
        int held_bad;
        bus.IR = 16'hD0FF; bus.Continue = 1'b0;
        run_fetch(); step();
        checks++; if (obs !== M_LD_LED) begin errors++; $display("FAIL pause_led got=%h exp=%h", obs, M_LD_LED); end
        held_bad = 0;
        for (int i = 0; i < 50; i++) begin
            step();
            if (obs !== E_IDLE) held_bad++;
        end
        checks++; if (held_bad != 0) begin errors++; $display("FAIL pause_hold got=%0d bad cycles exp=0", held_bad); end
        bus.Continue = 1'b1;
        repeat (3) step();
        checks++; if (obs !== E_IDLE) begin errors++; $display("FAIL pause_cont_hi got=%h exp=%h", obs, E_IDLE); end
        bus.Continue = 1'b0;
        step();
        checks++; if (obs !== E_F1) begin errors++; $display("FAIL pause_f1 got=%h exp=%h", obs, E_F1); end
    endtask

    task automatic test_unsupported();
        bus.IR = 16'hF025;
        run_fetch(); step();
        checks++; if (obs !== E_F1) begin errors++; $display("FAIL nop_f1 got=%h exp=%h", obs, E_F1); end
    endtask

    task automatic test_random_run();
        int instr;
        int cyc;
        instr = 0;
        cyc   = 0;
        while (instr < 1000 && cyc < 20000) begin
            bus.IR       = 16'($urandom);
            bus.BEN      = 1'($urandom);
            bus.Continue = 1'($urandom);
            step();
            cyc++;
            if (bus.LD_IR === 1'b1) instr++;
            checks++;
            if ($countones(obs[18:15]) > 1) begin
                errors++; $display("FAIL rand_one_gate got=%b exp=at most one", obs[18:15]);
            end
            checks++;
            if ((bus.Mem_OE & bus.Mem_WE) !== 1'b0) begin
                errors++; $display("FAIL rand_mem_excl got=OE%b WE%b exp=not both", bus.Mem_OE, bus.Mem_WE);
            end
        end
        checks++; if (instr < 1000) begin errors++; $display("FAIL rand_progress got=%0d exp=1000", instr); end
        #2 rst_n = 1'b0;
        #1;
        checks++; if (obs !== E_HALT) begin errors++; $display("FAIL rand_reset got=%h exp=%h", obs, E_HALT); end
        @(negedge clk); rst_n = 1'b1;
    endtask

    initial begin
        checks = 0;
        errors = 0;
        rst_n = 1'b0;
        bus.Run = 1'b0; bus.Continue = 1'b0; bus.IR = 16'h0000; bus.BEN = 1'b0;
        test_reset();
        test_fetch_add();
        test_alu_ops();
        test_branch();
        test_jmp_jsr();
        test_ldr();
        test_str();
        test_pause();
        test_unsupported();
        test_random_run();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
